ex_redirect_ctrl: RTL and testbench

//   EX-stage control-flow redirect controller for the pipelined RISC core.

---
 rtl/ex_redirect_ctrl.sv | 123 ++++++++++++
 tb/tb_ex_redirect_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_redirect_ctrl.sv
// rtl/ex_redirect_ctrl.sv - EX-stage redirect controller: registered PC redirect, IF handshake, post-accept flush
// Captures taken BEQ/JAL/JLR in EX, holds the redirect until IF accepts it, then squashes younger stages.
module ex_redirect_ctrl #(
  parameter int              OPW         = 4,
  parameter int              PCW         = 16,
  parameter int              FLUSH_DEPTH = 2,
  parameter int              CNTW        = 8,
  parameter logic [OPW-1:0]  OPC_BEQ     = 4'b1100,
  parameter logic [OPW-1:0]  OPC_JAL     = 4'b1000,
  parameter logic [OPW-1:0]  OPC_JLR     = 4'b1001
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_kill,
  input  logic [OPW-1:0]  opcode,
  input  logic            alu_zero,
  input  logic [PCW-1:0]  br_target,
  input  logic [PCW-1:0]  jlr_target,
  input  logic            if_ready,
  output logic            redirect_valid,
  output logic [PCW-1:0]  redirect_pc,
  output logic [1:0]      pc_sel,
  output logic            flush,
  output logic            busy,
  output logic [CNTW-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PEND  = 2'b01,
    FLUSH = 2'b10
  } state_t;

  localparam logic [3:0] FCNT_INIT = (FLUSH_DEPTH > 0) ? 4'(FLUSH_DEPTH - 1) : 4'd0;

  state_t          state, state_n;
  logic [3:0]      fcnt, fcnt_n;
  logic            valid_n, flush_n;
  logic [PCW-1:0]  pc_n;
  logic [1:0]      sel_n;
  logic [CNTW-1:0] cnt_n;
  logic            is_jlr, take;

  assign is_jlr = (opcode == OPC_JLR);
  assign take   = ~ex_kill & (((opcode == OPC_BEQ) & alu_zero) | (opcode == OPC_JAL) | is_jlr);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      fcnt           <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      pc_sel         <= 2'b00;
      flush          <= 1'b0;
      taken_cnt      <= '0;
    end else begin
      state          <= state_n;
      fcnt           <= fcnt_n;
      redirect_valid <= valid_n;
      redirect_pc    <= pc_n;
      pc_sel         <= sel_n;
      flush          <= flush_n;
      taken_cnt      <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    valid_n = redirect_valid;
    pc_n    = redirect_pc;
    sel_n   = pc_sel;
    flush_n = flush;
    cnt_n   = taken_cnt;
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        sel_n   = 2'b00;
        flush_n = 1'b0;
        if (take) begin
          state_n = PEND;
          valid_n = 1'b1;
          flush_n = 1'b1;
          pc_n    = is_jlr ? jlr_target : br_target;
          sel_n   = is_jlr ? 2'b01 : 2'b10;
        end
      end
      PEND: begin
        // Takes seen here are wrong-path and deliberately ignored.
        if (redirect_valid && if_ready) begin
          valid_n = 1'b0;
          sel_n   = 2'b00;
          if (taken_cnt != {CNTW{1'b1}}) cnt_n = taken_cnt + CNTW'(1);
          if (FLUSH_DEPTH > 0) begin
            state_n = FLUSH;
            fcnt_n  = FCNT_INIT;
            flush_n = 1'b1;
          end else begin
            state_n = IDLE;
            flush_n = 1'b0;
          end
        end
      end
      FLUSH: begin
        flush_n = 1'b1;
        if (fcnt == 4'd0) begin
          state_n = IDLE;
          flush_n = 1'b0;
        end else begin
          fcnt_n = fcnt - 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        sel_n   = 2'b00;
        flush_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ex_redirect_ctrl.sv
// tb/tb_ex_redirect_ctrl.sv - scoreboard bench for ex_redirect_ctrl (default build plus CNTW=2/FLUSH_DEPTH=0 build)
module tb_ex_redirect_ctrl;

  localparam logic [3:0] BEQ = 4'b1100;
  localparam logic [3:0] JAL = 4'b1000;
  localparam logic [3:0] JLR = 4'b1001;

  logic        clk = 1'b0;
  logic        reset, ex_kill, alu_zero, if_ready;
  logic [3:0]  opcode;
  logic [15:0] br_target, jlr_target;

  logic        rv, fl, bz;
  logic [15:0] rpc;
  logic [1:0]  sel;
  logic [7:0]  cnt;

  logic        rv2, fl2, bz2;
  logic [15:0] rpc2;
  logic [1:0]  sel2;
  logic [1:0]  cnt2;

  typedef struct packed {
    logic [15:0] pc;
    logic [1:0]  sel;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  ex_redirect_ctrl dut (
    .clk(clk), .reset(reset), .ex_kill(ex_kill), .opcode(opcode), .alu_zero(alu_zero),
    .br_target(br_target), .jlr_target(jlr_target), .if_ready(if_ready),
    .redirect_valid(rv), .redirect_pc(rpc), .pc_sel(sel), .flush(fl), .busy(bz), .taken_cnt(cnt)
  );

  ex_redirect_ctrl #(.CNTW(2), .FLUSH_DEPTH(0)) dut2 (
    .clk(clk), .reset(reset), .ex_kill(ex_kill), .opcode(opcode), .alu_zero(alu_zero),
    .br_target(br_target), .jlr_target(jlr_target), .if_ready(if_ready),
    .redirect_valid(rv2), .redirect_pc(rpc2), .pc_sel(sel2), .flush(fl2), .busy(bz2), .taken_cnt(cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic az, input logic kill,
                       input logic [15:0] bt, input logic [15:0] jt);
    opcode = op; alu_zero = az; ex_kill = kill; br_target = bt; jlr_target = jt;
  endtask

  task automatic bubble();
    drive(4'b0000, 1'b0, 1'b1, 16'h0000, 16'h0000);
  endtask

  task automatic test_reset();
    reset = 1'b1; bubble(); if_ready = 1'b0;
    step(); step();
    total++; if (rv !== 1'b0)     begin bad++; $display("FAIL reset_valid got=%0b exp=0", rv); end
    total++; if (rpc !== 16'h0)   begin bad++; $display("FAIL reset_pc got=%0h exp=0", rpc); end
    total++; if (sel !== 2'b00)   begin bad++; $display("FAIL reset_sel got=%0b exp=00", sel); end
    total++; if (fl !== 1'b0)     begin bad++; $display("FAIL reset_flush got=%0b exp=0", fl); end
    total++; if (bz !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%0b exp=0", bz); end
    total++; if (cnt !== 8'd0)    begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_beq_accept();
    exp_t e;
    drive(BEQ, 1'b1, 1'b0, 16'h0040, 16'h0abc); if_ready = 1'b1;
    sb.push_back('{pc: 16'h0040, sel: 2'b10});
    step(); bubble();
    total++; if (rv !== 1'b1) begin bad++; $display("FAIL beq_valid got=%0b exp=1", rv); end
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL beq_sb_empty got=0 exp=1"); end
    else begin
      e = sb.pop_front();
      if (rpc !== e.pc || sel !== e.sel) begin
        bad++; $display("FAIL beq_redirect got=%0h/%0b exp=%0h/%0b", rpc, sel, e.pc, e.sel);
      end
    end
    total++; if (fl !== 1'b1) begin bad++; $display("FAIL beq_flush_pend got=%0b exp=1", fl); end
    step();
    exp_cnt++;
    total++; if (rv !== 1'b0 || sel !== 2'b00) begin bad++; $display("FAIL beq_post_accept got=%0b/%0b exp=0/00", rv, sel); end
    total++; if (fl !== 1'b1) begin bad++; $display("FAIL beq_flush1 got=%0b exp=1", fl); end
    total++; if (cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL beq_cnt got=%0d exp=%0d", cnt, exp_cnt); end
    total++; if (fl2 !== 1'b0 || bz2 !== 1'b0) begin bad++; $display("FAIL fd0_flush got=%0b/%0b exp=0/0", fl2, bz2); end
    total++; if (cnt2 !== 2'd1) begin bad++; $display("FAIL fd0_cnt got=%0d exp=1", cnt2); end
    step();
    total++; if (fl !== 1'b1) begin bad++; $display("FAIL beq_flush2 got=%0b exp=1", fl); end
    step();
    total++; if (fl !== 1'b0 || bz !== 1'b0) begin bad++; $display("FAIL beq_idle got=%0b/%0b exp=0/0", fl, bz); end
  endtask

  task automatic test_jlr_hold();
    exp_t e;
    drive(JLR, 1'b0, 1'b0, 16'h0777, 16'h1234); if_ready = 1'b0;
    sb.push_back('{pc: 16'h1234, sel: 2'b01});
    step(); bubble();
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL jlr_sb_empty got=0 exp=1"); e = '0; end
    else e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rv !== 1'b1 || rpc !== e.pc || sel !== e.sel || fl !== 1'b1) begin
        bad++; $display("FAIL jlr_hold%0d got=%0b/%0h/%0b/%0b exp=1/%0h/%0b/1", i, rv, rpc, sel, fl, e.pc, e.sel);
      end
      if (i == 3) if_ready = 1'b1;
      step();
    end
    exp_cnt++;
    if_ready = 1'b0;
    total++; if (rv !== 1'b0 || fl !== 1'b1 || cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL jlr_accept got=%0b/%0b/%0d exp=0/1/%0d", rv, fl, cnt, exp_cnt); end
    step();
    total++; if (fl !== 1'b1) begin bad++; $display("FAIL jlr_flush2 got=%0b exp=1", fl); end
    step();
    total++; if (fl !== 1'b0 || bz !== 1'b0) begin bad++; $display("FAIL jlr_idle got=%0b/%0b exp=0/0", fl, bz); end
  endtask

  task automatic test_no_take();
    logic [3:0] ops [3] = '{BEQ, JAL, 4'b0011};
    logic       kills [3] = '{1'b0, 1'b1, 1'b0};
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 1'b0, kills[i], 16'h00f0, 16'h0f00);
      step();
      total++;
      if (rv !== 1'b0 || fl !== 1'b0 || bz !== 1'b0 || cnt !== 8'(exp_cnt)) begin
        bad++; $display("FAIL no_take%0d got=%0b/%0b/%0b/%0d exp=0/0/0/%0d", i, rv, fl, bz, cnt, exp_cnt);
      end
    end
    bubble();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    drive(JAL, 1'b0, 1'b0, 16'h0100, 16'h0000); if_ready = 1'b1;
    sb.push_back('{pc: 16'h0100, sel: 2'b10});
    step();
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL b2b_sb_empty got=0 exp=1"); end
    else begin
      e = sb.pop_front();
      if (rv !== 1'b1 || rpc !== e.pc || sel !== e.sel) begin
        bad++; $display("FAIL b2b_jal1 got=%0b/%0h/%0b exp=1/%0h/%0b", rv, rpc, sel, e.pc, e.sel);
      end
    end
    drive(JLR, 1'b0, 1'b0, 16'h0000, 16'h0bad);
    step(); exp_cnt++;
    step();
    total++; if (rv !== 1'b0 || fl !== 1'b1 || bz !== 1'b1) begin bad++; $display("FAIL b2b_flush got=%0b/%0b/%0b exp=0/1/1", rv, fl, bz); end
    step();
    total++; if (rv !== 1'b0 || bz !== 1'b0 || cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL b2b_jlr_ignored got=%0b/%0b/%0d exp=0/0/%0d", rv, bz, cnt, exp_cnt); end
    drive(JAL, 1'b0, 1'b0, 16'h0200, 16'h0bad);
    sb.push_back('{pc: 16'h0200, sel: 2'b10});
    step(); bubble();
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL b2b_sb2_empty got=0 exp=1"); end
    else begin
      e = sb.pop_front();
      if (rv !== 1'b1 || rpc !== e.pc || sel !== e.sel) begin
        bad++; $display("FAIL b2b_jal2 got=%0b/%0h/%0b exp=1/%0h/%0b", rv, rpc, sel, e.pc, e.sel);
      end
    end
    step(); exp_cnt++;
    step(); step();
    total++; if (bz !== 1'b0 || cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL b2b_end got=%0b/%0d exp=0/%0d", bz, cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    drive(JAL, 1'b0, 1'b0, 16'h0055, 16'h0000); if_ready = 1'b0;
    step(); bubble();
    total++; if (rv !== 1'b1 || bz !== 1'b1) begin bad++; $display("FAIL rmid_pend got=%0b/%0b exp=1/1", rv, bz); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_cnt = 0;
    total++;
    if (rv !== 1'b0 || fl !== 1'b0 || sel !== 2'b00 || cnt !== 8'd0 || bz !== 1'b0) begin
      bad++; $display("FAIL rmid_abort got=%0b/%0b/%0b/%0d/%0b exp=0/0/00/0/0", rv, fl, sel, cnt, bz);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int n;
    for (int k = 0; k < 5; k++) begin
      drive(JAL, 1'b0, 1'b0, 16'(16'h0300 + k), 16'h0000); if_ready = 1'b1;
      sb.push_back('{pc: 16'(16'h0300 + k), sel: 2'b10});
      step(); bubble();
      total++;
      if (sb.size() == 0) begin bad++; $display("FAIL sat_sb_empty%0d got=0 exp=1", k); end
      else begin
        e = sb.pop_front();
        if (rv !== 1'b1 || rpc !== e.pc || rpc2 !== e.pc) begin
          bad++; $display("FAIL sat_redirect%0d got=%0h/%0h exp=%0h", k, rpc, rpc2, e.pc);
        end
      end
      step(); exp_cnt++;
      n = 0;
      while (bz && n < 20) begin step(); n++; end
      total++; if (bz !== 1'b0) begin bad++; $display("FAIL sat_timeout%0d got=busy exp=idle", k); end
    end
    total++; if (cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL sat_cnt8 got=%0d exp=%0d", cnt, exp_cnt); end
    total++; if (cnt2 !== 2'd3) begin bad++; $display("FAIL sat_cnt2 got=%0d exp=3", cnt2); end
  endtask

  initial begin
    if_ready = 1'b0; reset = 1'b1; bubble();
    test_reset();
    test_beq_accept();
    test_jlr_hold();
    test_no_take();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
